// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first a - b - b_in with a borrow flop.
// All state advances on the falling edge of clk so it can sit alongside the
// registered full-adder cell in one datapath. The difference is streamed on
// d_bit/d_valid and also delivered as a parallel word with borrow-out and a
// one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             d_bit,
  output logic             d_valid,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;

  logic a0;
  logic b0;
  logic d_cur;
  logic br_nx;

  // One bit slice of the subtractor: difference and borrow for the current LSBs.
  assign a0    = a_sh[0];
  assign b0    = b_sh[0];
  assign d_cur = a0 ^ b0 ^ br;
  assign br_nx = (~a0 & b0) | (~(a0 ^ b0) & br);

  // Control FSM plus datapath; every output is registered. busy stays high
  // through the done-pulse cycle so the whole operation spans WIDTH+2 edges.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      br      <= 1'b0;
      busy    <= 1'b0;
      d_bit   <= 1'b0;
      d_valid <= 1'b0;
      diff    <= '0;
      b_out   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          br      <= br_nx;
          res     <= {d_cur, res[WIDTH-1:1]};
          d_bit   <= d_cur;
          d_valid <= 1'b1;
          cnt     <= cnt + CW'(1);
          busy    <= 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          diff  <= res;
          b_out <= br;
          done  <= 1'b1;
          busy  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
